// File: rtl/comp_storage_arbiter_pkg.sv
// Shared types for the computation-storage command path.
package CompPkg;

  localparam int unsigned addrSize = 8;
  localparam int unsigned dataSize = 8;

  // Storage command encoding; RD of address 0 doubles as the idle bus value.
  typedef enum logic [1:0] {
    RD_MEM_CMD = 2'd0,
    WR_MEM_CMD = 2'd1,
    ADD_CMD    = 2'd2,
    SUB_CMD    = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StExec,
    StRdWait,
    StResp
  } arb_state_t;

  typedef struct packed {
    op_t                 op;
    logic [addrSize-1:0] addA;
    logic [addrSize-1:0] addB;
    logic [addrSize-1:0] addC;
    logic [dataSize-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/comp_storage_arbiter_rr_picker.sv
// Combinational round-robin picker: first request at or above rr_ptr, with wrap.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  int unsigned idx;

  // Scan NUM_REQ slots starting at rr_ptr; the first hit wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        winner     = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/comp_storage_arbiter.sv
// Round-robin arbiter serialising requester commands onto one storage bus.
module comp_storage_arbiter
  import CompPkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = $clog2(NUM_REQ),
  parameter int unsigned addrSize = CompPkg::addrSize,
  parameter int unsigned dataSize = CompPkg::dataSize
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*2-1:0]         req_op,
  input  logic [NUM_REQ*addrSize-1:0]  req_addA,
  input  logic [NUM_REQ*addrSize-1:0]  req_addB,
  input  logic [NUM_REQ*addrSize-1:0]  req_addC,
  input  logic [NUM_REQ*dataSize-1:0]  req_wdata,
  output logic                         rsp_valid,
  output logic [ID_W-1:0]              rsp_id,
  output logic [dataSize-1:0]          rsp_data,
  output op_t                          mem_op,
  output logic [addrSize-1:0]          mem_addA,
  output logic [addrSize-1:0]          mem_addB,
  output logic [addrSize-1:0]          mem_addC,
  output logic [dataSize-1:0]          mem_dq_out,
  output logic                         mem_dq_oe,
  input  logic [dataSize-1:0]          mem_dq_in,
  output logic                         busy
);

  arb_state_t           state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      win_q, win_d;
  cmd_t                 cmd_q, cmd_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [dataSize-1:0]  rsp_data_q, rsp_data_d;
  op_t                  mem_op_q, mem_op_d;
  logic [addrSize-1:0]  add_a_q, add_a_d, add_b_q, add_b_d, add_c_q, add_c_d;
  logic [dataSize-1:0]  dq_out_q, dq_out_d;
  logic                 dq_oe_q, dq_oe_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [ID_W-1:0]      pick_win;
  logic                 pick_any;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .winner (pick_win),
    .any    (pick_any)
  );

  // Next-state and registered-output computation; the bus defaults to idle (RD of 0).
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    cmd_d       = cmd_q;
    ready_d     = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    mem_op_d    = RD_MEM_CMD;
    add_a_d     = '0;
    add_b_d     = '0;
    add_c_d     = '0;
    dq_out_d    = '0;
    dq_oe_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          cmd_d.op    = op_t'(req_op[32'(pick_win) * 2 +: 2]);
          cmd_d.addA  = req_addA[32'(pick_win) * addrSize +: addrSize];
          cmd_d.addB  = req_addB[32'(pick_win) * addrSize +: addrSize];
          cmd_d.addC  = req_addC[32'(pick_win) * addrSize +: addrSize];
          cmd_d.wdata = req_wdata[32'(pick_win) * dataSize +: dataSize];
          ready_d     = pick_grant;
          win_d       = pick_win;
          rr_ptr_d    = (32'(pick_win) == NUM_REQ - 1) ? '0 : pick_win + ID_W'(1);
          state_d     = StGrant;
        end
      end
      StGrant: begin
        mem_op_d = cmd_q.op;
        add_a_d  = cmd_q.addA;
        add_b_d  = cmd_q.addB;
        add_c_d  = cmd_q.addC;
        if (cmd_q.op == WR_MEM_CMD) begin
          dq_out_d = cmd_q.wdata;
          dq_oe_d  = 1'b1;
        end
        state_d = StExec;
      end
      // Storage samples the command at the end of this cycle.
      StExec: state_d = (cmd_q.op == RD_MEM_CMD) ? StRdWait : StIdle;
      StRdWait: begin
        rsp_data_d  = mem_dq_in;
        rsp_id_d    = win_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset forces the idle bus immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      cmd_q       <= '0;
      ready_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      mem_op_q    <= RD_MEM_CMD;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_c_q     <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      cmd_q       <= cmd_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      mem_op_q    <= mem_op_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_c_q     <= add_c_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign mem_op     = mem_op_q;
  assign mem_addA   = add_a_q;
  assign mem_addB   = add_b_q;
  assign mem_addC   = add_c_q;
  assign mem_dq_out = dq_out_q;
  assign mem_dq_oe  = dq_oe_q;
  assign busy       = busy_q;

endmodule
